// File: rtl/avm_uart_responder.sv
// avm_uart_responder: Avalon-MM slave modelling the polled RS232 UART register
// file (RX data, TX data, STATUS). Bytes flow between a valid/ready byte-stream
// host side and the bus through two FIFOs; every bus access is stretched by a
// fixed number of waitrequest cycles.
module avm_uart_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
  localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

  logic [3:0]    r_cnt;
  logic [31:0]   r_rdata;
  logic          r_rx_pop_ok;
  logic          r_txdrop;
  logic [AW:0]   r_rx_wr;
  logic [AW:0]   r_rx_rd;
  logic [AW:0]   r_tx_wr;
  logic [AW:0]   r_tx_rd;
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [7:0]    r_tx_mem [FIFO_DEPTH];

  logic          w_req;
  logic          w_done;
  logic          w_load;
  logic          w_is_rd;
  logic          w_is_wr;
  logic [2:0]    w_idx;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic [7:0]    w_rx_head;
  logic [7:0]    w_tx_head;
  logic [31:0]   w_rd_value;
  logic          w_unused_bits;

  assign w_req   = avm_read | avm_write;
  assign w_is_rd = avm_read;
  // A simultaneous read and write is handled as a read only.
  assign w_is_wr = avm_write & ~avm_read;
  assign w_idx   = avm_address[4:2];
  assign w_done  = w_req && (r_cnt == LP_WAIT);
  assign w_load  = w_req && (r_cnt == LP_LOAD);

  assign w_unused_bits = ^{avm_address[1:0], avm_writedata[31:10], avm_writedata[8]};

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);

  assign w_rx_head = r_rx_mem[r_rx_rd[AW-1:0]];
  assign w_tx_head = r_tx_mem[r_tx_rd[AW-1:0]];

  // Stream-side handshakes depend only on FIFO state and reset, never on the bus request.
  assign rx_ready = avm_rst_n & ~w_rx_full;
  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_empty ? 8'h00 : w_tx_head;

  assign w_rx_push = rx_valid & rx_ready;
  assign w_tx_pop  = tx_valid & tx_ready;
  // The pop decision is tied to what was captured into readdata, so a byte
  // arriving between load and completion is never discarded unseen.
  assign w_rx_pop  = w_done & w_is_rd & (w_idx == 3'd0) & r_rx_pop_ok & ~w_rx_empty;
  assign w_tx_push = w_done & w_is_wr & (w_idx == 3'd1) & ~w_tx_full;

  assign avm_waitrequest = ~avm_rst_n | (w_req && (r_cnt != LP_WAIT));
  assign avm_readdata    = r_rdata;

  // Register-file read mux, evaluated at the readdata load edge.
  always_comb begin
    w_rd_value = 32'h0;
    case (w_idx)
      3'd0: if (!w_rx_empty) w_rd_value = {24'h0, w_rx_head};
      3'd2: begin
        w_rd_value[9] = r_txdrop;
        w_rd_value[7] = ~w_rx_empty;
        w_rd_value[6] = ~w_tx_full;
      end
      default: w_rd_value = 32'h0;
    endcase
  end

  // Access counter: counts waitrequest cycles, clears on completion or abort.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_cnt <= 4'd0;
    end else if (!w_req || w_done) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Readdata register, loaded one edge before completion and held until the next load.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_rdata     <= 32'h0;
      r_rx_pop_ok <= 1'b0;
    end else if (w_load) begin
      r_rdata     <= w_rd_value;
      r_rx_pop_ok <= ~w_rx_empty;
    end
  end

  // Sticky TX drop flag: set by a write into a full TX FIFO, cleared through STATUS bit 9.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_txdrop <= 1'b0;
    end else if (w_done && w_is_wr) begin
      if ((w_idx == 3'd1) && w_tx_full) begin
        r_txdrop <= 1'b1;
      end else if ((w_idx == 3'd2) && avm_writedata[9]) begin
        r_txdrop <= 1'b0;
      end
    end
  end

  // FIFO pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + (AW+1)'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + (AW+1)'(1);
      if (w_tx_push) r_tx_wr <= r_tx_wr + (AW+1)'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge avm_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= avm_writedata[7:0];
  end

endmodule
